// File: rtl/mem_wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_pkg
// Shared definitions for the memory-access stage and its MEM/WB register:
//   - mem_state_t      : access FSM state encoding (IDLE / WAIT)
//   - WORD_ALIGN_MASK  : address bits that must be zero for a word access
//   - BUBBLE_*         : values loaded into MEM/WB when no instruction retires
//   - wb_bundle_t      : the write-back payload carried by MEM/WB
//   - helper functions for alignment checks and word address formation
// -----------------------------------------------------------------------------
package mem_wb_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [1:0] WORD_ALIGN_MASK  = 2'b11;
  localparam logic [4:0] BUBBLE_RD        = 5'd0;
  localparam logic       BUBBLE_REG_WRITE = 1'b0;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        reg_write;
  } wb_bundle_t;

  // True when the byte offset of an address is not word aligned.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return |(low_bits & WORD_ALIGN_MASK);
  endfunction

  // Clears the byte offset so the memory always sees a word address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~{30'd0, WORD_ALIGN_MASK};
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_if
// Data-memory port used by the memory-access stage.
//   req   : access request (stage -> memory)
//   we    : 1 = store, 0 = load
//   addr  : word-aligned byte address
//   wdata : store data
//   rdata : load data, valid in the cycle ready is high
//   ready : access completes this cycle (memory -> stage)
// The master modport is the pipeline stage, the slave modport is the memory.
// -----------------------------------------------------------------------------
interface mem_wb_stage_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ready
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ready
  );

endinterface

// File: rtl/mem_wb_stage_mem_access_fsm.sv
// -----------------------------------------------------------------------------
// mem_access_fsm
// Tracks one outstanding data-memory access and decides, each cycle, whether
// the access is requested, stalls the pipeline, completes, or is aborted
// because the memory has not answered within TIMEOUT stall cycles.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   access     in   aligned load/store present in EX/MEM
//   dmem_ready in   memory completes the access this cycle
//   dmem_req   out  access request to memory (combinational)
//   mem_stall  out  hold upstream pipeline this cycle (combinational)
//   abort      out  access given up this cycle (combinational)
//   complete   out  access finishes this cycle (combinational)
// -----------------------------------------------------------------------------
module mem_access_fsm
  import mem_wb_stage_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic access,
  input  logic dmem_ready,
  output logic dmem_req,
  output logic mem_stall,
  output logic abort,
  output logic complete
);

  mem_state_t       state_reg;
  mem_state_t       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             at_limit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // cnt_reg counts stall cycles already spent on the current access, so an
  // access that never sees ready stalls exactly TIMEOUT cycles and is then
  // aborted in the following cycle without a request or stall.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dmem_req   = 1'b0;
    abort      = 1'b0;
    complete   = 1'b0;
    at_limit   = (cnt_reg == CNT_W'(TIMEOUT));

    case (state_reg)
      IDLE: begin
        dmem_req = access;
        if (access) begin
          if (dmem_ready) begin
            // zero-wait access: finishes without leaving IDLE
            complete = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(1);
          end
        end
      end

      WAIT: begin
        if (!access) begin
          // instruction vanished (should not happen while stalled); recover
          state_next = IDLE;
          cnt_next   = '0;
        end else if (dmem_ready) begin
          dmem_req   = 1'b1;
          complete   = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else if (at_limit) begin
          abort      = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          dmem_req = 1'b1;
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // While reset is held the request is withdrawn immediately, even if the
    // EX/MEM inputs still describe a memory instruction.
    if (!reset) begin
      dmem_req = 1'b0;
      abort    = 1'b0;
      complete = 1'b0;
    end

    mem_stall = dmem_req & ~dmem_ready;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// Memory-access stage plus MEM/WB pipeline register. Performs word loads and
// stores on a variable-latency memory port, stalls the upstream pipeline while
// an access is outstanding, resolves branches, and registers write-back data.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   alu_result, store_data      EX/MEM address/result and store data
//   rd_addr, reg_write          destination register and its write enable
//   zero, branch, jump          branch resolution inputs
//   mem_read, mem_write         load / store
//   mem_to_reg                  write-back selects load data
//   dmem                        data-memory port (master side)
//   mem_stall                   hold PC..EX/MEM this cycle (combinational)
//   pc_src, jump_out            branch taken / jump passthrough (combinational)
//   wb_data, wb_rd, wb_reg_write registered write-back payload
//   misalign_err, bus_err       registered one-cycle error pulses
// -----------------------------------------------------------------------------
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    alu_result,
  input  logic [31:0]    store_data,
  input  logic [4:0]     rd_addr,
  input  logic           zero,
  input  logic           branch,
  input  logic           jump,
  input  logic           mem_read,
  input  logic           mem_write,
  input  logic           mem_to_reg,
  input  logic           reg_write,
  mem_wb_stage_if.master dmem,
  output logic           mem_stall,
  output logic           pc_src,
  output logic           jump_out,
  output logic [31:0]    wb_data,
  output logic [4:0]     wb_rd,
  output logic           wb_reg_write,
  output logic           misalign_err,
  output logic           bus_err
);

  logic       mem_op;
  logic       misalign;
  logic       access;
  logic       access_req;
  logic       abort;
  logic       complete;
  logic       capture_bubble;
  wb_bundle_t wb_reg;
  wb_bundle_t wb_next;
  logic       misalign_err_reg;
  logic       bus_err_reg;

  // Address decode: a misaligned access never reaches the memory.
  assign mem_op   = mem_read | mem_write;
  assign misalign = mem_op & is_misaligned(alu_result[1:0]);
  assign access   = mem_op & ~misalign;

  mem_access_fsm #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .access     (access),
    .dmem_ready (dmem.ready),
    .dmem_req   (access_req),
    .mem_stall  (mem_stall),
    .abort      (abort),
    .complete   (complete)
  );

  // Memory port. Load+store together is treated as a store.
  assign dmem.req   = access_req;
  assign dmem.we    = mem_write;
  assign dmem.addr  = word_align(alu_result);
  assign dmem.wdata = store_data;

  assign pc_src   = branch & zero;
  assign jump_out = jump;

  // MEM/WB capture. A stalled, aborted or misaligned instruction does not
  // retire, so a bubble is inserted; wb_data keeps its old value because only
  // wb_reg_write qualifies it downstream.
  always_comb begin
    wb_next        = wb_reg;
    capture_bubble = misalign | abort | mem_stall;
    if (capture_bubble) begin
      wb_next.rd        = BUBBLE_RD;
      wb_next.reg_write = BUBBLE_REG_WRITE;
    end else begin
      wb_next.data      = (complete & mem_to_reg) ? dmem.rdata : alu_result;
      wb_next.rd        = rd_addr;
      wb_next.reg_write = reg_write;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_reg           <= '0;
      misalign_err_reg <= 1'b0;
      bus_err_reg      <= 1'b0;
    end else begin
      wb_reg           <= wb_next;
      misalign_err_reg <= misalign;
      bus_err_reg      <= abort;
    end
  end

  assign wb_data      = wb_reg.data;
  assign wb_rd        = wb_reg.rd;
  assign wb_reg_write = wb_reg.reg_write;
  assign misalign_err = misalign_err_reg;
  assign bus_err      = bus_err_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
// Self-checking bench for mem_wb_stage: table of single-cycle vectors, hand
// sequences for wait states, timeout and reset-during-wait, then randomized
// instructions checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] alu_result, store_data;
  logic [4:0]  rd_addr;
  logic        zero, branch, jump, mem_read, mem_write, mem_to_reg, reg_write;
  logic        mem_stall, pc_src, jump_out;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, misalign_err, bus_err;

  mem_wb_stage_if dmem ();

  mem_wb_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .rd_addr      (rd_addr),
    .zero         (zero),
    .branch       (branch),
    .jump         (jump),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .dmem         (dmem),
    .mem_stall    (mem_stall),
    .pc_src       (pc_src),
    .jump_out     (jump_out),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_insn(input logic [31:0] a, input logic [31:0] s, input logic [4:0] r,
                          input logic z, input logic b, input logic j,
                          input logic mr, input logic mw, input logic m2r, input logic rw);
    alu_result = a; store_data = s; rd_addr = r;
    zero = z; branch = b; jump = j;
    mem_read = mr; mem_write = mw; mem_to_reg = m2r; reg_write = rw;
  endtask

  typedef struct {
    logic [31:0] alu, sdata;
    logic [4:0]  rd;
    logic        zero, branch, jump, mrd, mwr, m2r, rw, ready;
    logic [31:0] rdata;
    logic        e_req, e_we, e_stall, e_pc, e_jmp;
    logic [31:0] e_wbd;
    logic [4:0]  e_wbrd;
    logic        e_wbwe, e_mis;
  } vec_t;

  function automatic vec_t mkv(
      input logic [31:0] alu, input logic [31:0] sdata, input logic [4:0] rd,
      input logic zero, input logic branch, input logic jump,
      input logic mrd, input logic mwr, input logic m2r, input logic rw,
      input logic ready, input logic [31:0] rdata,
      input logic e_req, input logic e_we, input logic e_stall, input logic e_pc, input logic e_jmp,
      input logic [31:0] e_wbd, input logic [4:0] e_wbrd, input logic e_wbwe, input logic e_mis);
    vec_t v;
    v.alu = alu; v.sdata = sdata; v.rd = rd; v.zero = zero; v.branch = branch; v.jump = jump;
    v.mrd = mrd; v.mwr = mwr; v.m2r = m2r; v.rw = rw; v.ready = ready; v.rdata = rdata;
    v.e_req = e_req; v.e_we = e_we; v.e_stall = e_stall; v.e_pc = e_pc; v.e_jmp = e_jmp;
    v.e_wbd = e_wbd; v.e_wbrd = e_wbrd; v.e_wbwe = e_wbwe; v.e_mis = e_mis;
    return v;
  endfunction

  // Behavioural reference: number of stall cycles already spent on the
  // instruction currently held in EX/MEM, plus the expected MEM/WB contents.
  int          m_stalls;
  logic [31:0] m_data;
  logic [4:0]  m_rd;
  logic        m_we, m_mis, m_bus;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    logic [31:0] exp_addr;

    // ---------------- reset state ----------------
    reset = 1'b0;
    set_insn(32'h100, 32'h0, 5'd5, 0, 0, 0, 1, 0, 1, 1);
    dmem.ready = 1'b0; dmem.rdata = 32'h0;
    #1;
    chk("reset_req", dmem.req, 0);
    chk("reset_stall", mem_stall, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wb_data", wb_data, 0);
    chk("reset_wb_rd", wb_rd, 0);
    chk("reset_wb_we", wb_reg_write, 0);
    chk("reset_mis", misalign_err, 0);
    chk("reset_bus", bus_err, 0);
    $display("reset: wb_data=%h wb_rd=%0d wb_we=%b", wb_data, wb_rd, wb_reg_write);
    @(negedge clk);
    set_insn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // ---------------- single-cycle vector table ----------------
    vecs[0] = mkv(32'h55, 0, 9, 0,0,0, 0,0,0,1, 0, 0,
                  0,0,0,0,0, 32'h55, 9, 1, 0);
    vecs[1] = mkv(32'h100, 0, 5, 0,0,0, 1,0,1,1, 1, 32'hDEADBEEF,
                  1,0,0,0,0, 32'hDEADBEEF, 5, 1, 0);
    vecs[2] = mkv(32'h102, 0, 6, 0,0,0, 1,0,1,1, 0, 32'h11111111,
                  0,0,0,0,0, 32'hDEADBEEF, 0, 0, 1);
    vecs[3] = mkv(32'hA5A50000, 0, 3, 1,1,0, 0,0,0,1, 0, 0,
                  0,0,0,1,0, 32'hA5A50000, 3, 1, 0);
    vecs[4] = mkv(32'h7, 0, 0, 0,1,1, 0,0,0,1, 0, 0,
                  0,0,0,0,1, 32'h7, 0, 1, 0);
    vecs[5] = mkv(32'h300, 32'hCAFEF00D, 4, 0,0,0, 1,1,0,0, 1, 32'h22222222,
                  1,1,0,0,0, 32'h300, 4, 0, 0);
    vecs[6] = mkv(32'h301, 32'hCAFEF00D, 4, 0,0,0, 0,1,0,0, 0, 0,
                  0,1,0,0,0, 32'h300, 0, 0, 1);
    vecs[7] = mkv(32'h44, 0, 2, 0,0,0, 0,0,1,1, 1, 32'hFFFFFFFF,
                  0,0,0,0,0, 32'h44, 2, 1, 0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_insn(vecs[i].alu, vecs[i].sdata, vecs[i].rd, vecs[i].zero, vecs[i].branch,
               vecs[i].jump, vecs[i].mrd, vecs[i].mwr, vecs[i].m2r, vecs[i].rw);
      dmem.ready = vecs[i].ready; dmem.rdata = vecs[i].rdata;
      #1;
      exp_addr = vecs[i].alu & 32'hFFFF_FFFC;
      chk("vec_req", dmem.req, vecs[i].e_req);
      chk("vec_we", dmem.we, vecs[i].e_we);
      chk("vec_stall", mem_stall, vecs[i].e_stall);
      chk("vec_pc_src", pc_src, vecs[i].e_pc);
      chk("vec_jump_out", jump_out, vecs[i].e_jmp);
      chk("vec_addr", dmem.addr, exp_addr);
      chk("vec_wdata", dmem.wdata, vecs[i].sdata);
      @(posedge clk);
      #1;
      chk("vec_wb_data", wb_data, vecs[i].e_wbd);
      chk("vec_wb_rd", wb_rd, vecs[i].e_wbrd);
      chk("vec_wb_we", wb_reg_write, vecs[i].e_wbwe);
      chk("vec_mis", misalign_err, vecs[i].e_mis);
      $display("vec %0d: alu=%h wb_data=%h wb_rd=%0d wb_we=%b mis=%b",
               i, vecs[i].alu, wb_data, wb_rd, wb_reg_write, misalign_err);
    end

    // ---------------- 3-wait store ----------------
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_insn(32'h204, 32'h12345678, 5'd0, 0,0,0, 0,1,0,0);
      dmem.ready = (k == 3); dmem.rdata = 32'h0;
      #1;
      chk("st_stall", mem_stall, (k < 3));
      chk("st_we", dmem.we, 1);
      chk("st_addr", dmem.addr, 32'h204);
      chk("st_wdata", dmem.wdata, 32'h12345678);
      @(posedge clk);
      #1;
      chk("st_wb_we", wb_reg_write, 0);
    end
    $display("store3: addr=204 wdata=12345678 wb_we=%b", wb_reg_write);

    // ---------------- timeout, then fresh access from IDLE ----------------
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      set_insn(32'h400, 0, 5'd7, 0,0,0, 1,0,1,1);
      dmem.ready = (k == 6); dmem.rdata = 32'h0BADF00D;
      #1;
      chk("to_stall", mem_stall, (k < 4) || (k == 5));
      chk("to_req", dmem.req, (k != 4));
      @(posedge clk);
      #1;
      chk("to_bus_err", bus_err, (k == 4));
      if (k < 6) chk("to_wb_we", wb_reg_write, 0);
    end
    chk("to_wb_data", wb_data, 32'h0BADF00D);
    chk("to_wb_rd", wb_rd, 7);
    chk("to_wb_we_final", wb_reg_write, 1);
    $display("timeout: bus_err pulse seen, reload wb_data=%h", wb_data);

    // ---------------- reset mid-WAIT, then branch ----------------
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_insn(32'h500, 0, 5'd8, 0,0,0, 1,0,1,1);
      dmem.ready = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wait_req", dmem.req, 0);
    chk("rst_wait_stall", mem_stall, 0);
    chk("rst_wait_wb_data", wb_data, 0);
    chk("rst_wait_wb_rd", wb_rd, 0);
    chk("rst_wait_wb_we", wb_reg_write, 0);
    chk("rst_wait_bus", bus_err, 0);
    @(posedge clk);
    @(negedge clk);
    set_insn(32'h88, 0, 5'd1, 1,1,0, 0,0,0,0);
    reset = 1'b1;
    #1;
    chk("br_pc_src", pc_src, 1);
    chk("br_req", dmem.req, 0);
    @(posedge clk);
    #1;
    chk("br_wb_data", wb_data, 32'h88);
    chk("br_wb_rd", wb_rd, 1);
    $display("reset_wait+branch: pc_src ok, wb_data=%h", wb_data);

    // ---------------- randomized instructions vs model ----------------
    @(negedge clk);
    reset = 1'b0;
    set_insn(0, 0, 0, 0,0,0, 0,0,0,0);
    dmem.ready = 1'b0;
    m_stalls = 0; m_data = 0; m_rd = 0; m_we = 0; m_mis = 0; m_bus = 0;
    @(negedge clk);
    reset = 1'b1;

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, s;
      logic [4:0]  r;
      logic        z, b, j, mr, mw, m2r, rw, slow, done;
      int          kind, cyc, aborted;
      kind = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      s = $urandom; r = 5'($urandom);
      z = 1'($urandom); b = 1'($urandom); j = 1'($urandom);
      mr = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
      mw = (kind == 2) || (kind == 3);
      m2r = 1'($urandom); rw = 1'($urandom);
      slow = ($urandom_range(0, 4) == 0);
      done = 1'b0; cyc = 0; aborted = 0;
      while (!done) begin
        logic        mem_op, mis, acc, abt, e_req, e_stall, e_cmp;
        logic [31:0] rdv;
        @(negedge clk);
        set_insn(a, s, r, z, b, j, mr, mw, m2r, rw);
        dmem.ready = slow ? 1'b0 : ($urandom_range(0, 2) == 0);
        rdv = $urandom;
        dmem.rdata = rdv;
        #1;
        mem_op  = mr | mw;
        mis     = mem_op && (a % 4 != 0);
        acc     = mem_op && !mis;
        abt     = acc && !dmem.ready && (m_stalls == TIMEOUT);
        e_req   = acc && !abt;
        e_stall = e_req && !dmem.ready;
        e_cmp   = e_req && dmem.ready;
        chk("rnd_req", dmem.req, e_req);
        chk("rnd_stall", mem_stall, e_stall);
        chk("rnd_we", dmem.we, mw);
        chk("rnd_addr", dmem.addr, a - (a % 4));
        chk("rnd_wdata", dmem.wdata, s);
        chk("rnd_pc_src", pc_src, b & z);
        chk("rnd_jump", jump_out, j);
        @(posedge clk);
        #1;
        m_mis = mis;
        m_bus = abt;
        if (mis || abt || e_stall) begin
          m_rd = 0; m_we = 0;
          m_stalls = e_stall ? m_stalls + 1 : 0;
        end else begin
          m_data = (e_cmp && m2r) ? rdv : a;
          m_rd = r; m_we = rw;
          m_stalls = 0;
        end
        if (abt) aborted = 1;
        chk("rnd_wb_data", wb_data, m_data);
        chk("rnd_wb_rd", wb_rd, m_rd);
        chk("rnd_wb_we", wb_reg_write, m_we);
        chk("rnd_mis", misalign_err, m_mis);
        chk("rnd_bus", bus_err, m_bus);
        done = !e_stall;
        cyc++;
      end
      $display("txn %0d: alu=%h rd=%0d rd_en=%b wr_en=%b cycles=%0d abort=%0d wb_data=%h",
               n, a, r, mr, mw, cyc, aborted, wb_data);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
